// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: serialises icache, dcache and uncached requests onto the
// single AXI bridge transaction port, one transaction at a time.
// Base priority dc > uc > ic. Define ARB_AGING_EN to add per-requester age
// counters that promote a requester after AGE_LIMIT lost selections.
module mem_req_arbiter #(
    parameter int CL_WIDTH  = 512,
    parameter int AGE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ic_req,
    input  logic [31:0]         ic_addr,
    output logic                ic_done,
    output logic [CL_WIDTH-1:0] ic_rdata,
    input  logic                dc_req,
    input  logic                dc_we,
    input  logic [31:0]         dc_addr,
    input  logic [CL_WIDTH-1:0] dc_wdata,
    output logic                dc_done,
    output logic [CL_WIDTH-1:0] dc_rdata,
    input  logic                uc_req,
    input  logic [3:0]          uc_wstrb,
    input  logic [31:0]         uc_addr,
    input  logic [31:0]         uc_wdata,
    output logic                uc_done,
    output logic [31:0]         uc_rdata,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [1:0]          bus_id,
    output logic                bus_we,
    output logic                bus_line,
    output logic [31:0]         bus_addr,
    output logic [3:0]          bus_wstrb,
    output logic [CL_WIDTH-1:0] bus_wdata,
    input  logic                bus_done,
    input  logic [CL_WIDTH-1:0] bus_rdata,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ID_IC = 2'd0;
    localparam logic [1:0] ID_DC = 2'd1;
    localparam logic [1:0] ID_UC = 2'd2;

    generate
        if (AGE_LIMIT < 1 || AGE_LIMIT > 15) begin : g_bad_age_limit
            $error("mem_req_arbiter: AGE_LIMIT must lie in 1..15");
        end
    endgenerate

    state_t              state_r;
    state_t              next_state_s;
    logic [1:0]          win_id_s;
    logic                any_req_s;
    logic                load_s;
    logic                done_evt_s;

    logic                sel_we_s;
    logic                sel_line_s;
    logic [31:0]         sel_addr_s;
    logic [3:0]          sel_wstrb_s;
    logic [CL_WIDTH-1:0] sel_wdata_s;

    logic                bus_valid_r;
    logic [1:0]          bus_id_r;
    logic                bus_we_r;
    logic                bus_line_r;
    logic [31:0]         bus_addr_r;
    logic [3:0]          bus_wstrb_r;
    logic [CL_WIDTH-1:0] bus_wdata_r;
    logic                busy_r;
    logic                ic_done_r;
    logic                dc_done_r;
    logic                uc_done_r;
    logic [CL_WIDTH-1:0] ic_rdata_r;
    logic [CL_WIDTH-1:0] dc_rdata_r;
    logic [31:0]         uc_rdata_r;

    assign any_req_s  = ic_req | dc_req | uc_req;
    assign load_s     = (state_r == ST_IDLE) && any_req_s;
    assign done_evt_s = (state_r == ST_WAIT) && bus_done;

`ifdef ARB_AGING_EN
    localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

    logic [3:0] ic_age_r;
    logic [3:0] dc_age_r;
    logic [3:0] uc_age_r;
    logic       ic_aged_s;
    logic       dc_aged_s;
    logic       uc_aged_s;

    assign ic_aged_s = ic_req && (ic_age_r == AGE_MAX);
    assign dc_aged_s = dc_req && (dc_age_r == AGE_MAX);
    assign uc_aged_s = uc_req && (uc_age_r == AGE_MAX);

    // Next age value: winner clears, pending loser counts up to the limit.
    function automatic logic [3:0] age_step(input logic [3:0] age,
                                            input logic       req,
                                            input logic       won);
        if (won) begin
            return 4'd0;
        end else if (req && (age < AGE_MAX)) begin
            return age + 4'd1;
        end else begin
            return age;
        end
    endfunction

    // Winner select: aged requesters first (base order among them), then base priority.
    always_comb begin
        win_id_s = ID_IC;
        if (dc_aged_s) begin
            win_id_s = ID_DC;
        end else if (uc_aged_s) begin
            win_id_s = ID_UC;
        end else if (ic_aged_s) begin
            win_id_s = ID_IC;
        end else if (dc_req) begin
            win_id_s = ID_DC;
        end else if (uc_req) begin
            win_id_s = ID_UC;
        end else begin
            win_id_s = ID_IC;
        end
    end

    // Age counters move only on an actual selection in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_age_r <= 4'd0;
            dc_age_r <= 4'd0;
            uc_age_r <= 4'd0;
        end else if (load_s) begin
            ic_age_r <= age_step(ic_age_r, ic_req, win_id_s == ID_IC);
            dc_age_r <= age_step(dc_age_r, dc_req, win_id_s == ID_DC);
            uc_age_r <= age_step(uc_age_r, uc_req, win_id_s == ID_UC);
        end
    end
`else
    // Winner select: strict base priority dc > uc > ic.
    always_comb begin
        win_id_s = ID_IC;
        if (dc_req) begin
            win_id_s = ID_DC;
        end else if (uc_req) begin
            win_id_s = ID_UC;
        end else begin
            win_id_s = ID_IC;
        end
    end
`endif

    // Build the downstream payload for the selected requester.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_line_s  = 1'b0;
        sel_addr_s  = 32'd0;
        sel_wstrb_s = 4'd0;
        sel_wdata_s = {CL_WIDTH{1'b0}};
        case (win_id_s)
            ID_IC: begin
                sel_line_s = 1'b1;
                sel_addr_s = ic_addr;
            end
            ID_DC: begin
                sel_we_s   = dc_we;
                sel_line_s = 1'b1;
                sel_addr_s = dc_addr;
                if (dc_we) begin
                    sel_wstrb_s = 4'b1111;
                    sel_wdata_s = dc_wdata;
                end else begin
                    sel_wstrb_s = 4'd0;
                    sel_wdata_s = {CL_WIDTH{1'b0}};
                end
            end
            ID_UC: begin
                sel_we_s    = (uc_wstrb != 4'd0);
                sel_line_s  = 1'b0;
                sel_addr_s  = uc_addr;
                sel_wstrb_s = uc_wstrb;
                sel_wdata_s = {{(CL_WIDTH-32){1'b0}}, uc_wdata};
            end
            default: begin
                sel_we_s    = 1'b0;
                sel_line_s  = 1'b0;
                sel_addr_s  = 32'd0;
                sel_wstrb_s = 4'd0;
                sel_wdata_s = {CL_WIDTH{1'b0}};
            end
        endcase
    end

    // Next-state logic for the one-transaction-at-a-time sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus_ready) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus_done) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register; busy mirrors the state that is being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
        end
    end

    // Latch the payload on selection; it is then frozen until the next selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_valid_r <= 1'b0;
            bus_id_r    <= 2'd0;
            bus_we_r    <= 1'b0;
            bus_line_r  <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_wstrb_r <= 4'd0;
            bus_wdata_r <= {CL_WIDTH{1'b0}};
        end else if (load_s) begin
            bus_valid_r <= 1'b1;
            bus_id_r    <= win_id_s;
            bus_we_r    <= sel_we_s;
            bus_line_r  <= sel_line_s;
            bus_addr_r  <= sel_addr_s;
            bus_wstrb_r <= sel_wstrb_s;
            bus_wdata_r <= sel_wdata_s;
        end else if ((state_r == ST_ISSUE) && bus_ready) begin
            bus_valid_r <= 1'b0;
        end
    end

    // Completion: one-cycle done pulse to the winner, read data captured for reads only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_done_r  <= 1'b0;
            dc_done_r  <= 1'b0;
            uc_done_r  <= 1'b0;
            ic_rdata_r <= {CL_WIDTH{1'b0}};
            dc_rdata_r <= {CL_WIDTH{1'b0}};
            uc_rdata_r <= 32'd0;
        end else begin
            ic_done_r <= done_evt_s && (bus_id_r == ID_IC);
            dc_done_r <= done_evt_s && (bus_id_r == ID_DC);
            uc_done_r <= done_evt_s && (bus_id_r == ID_UC);
            if (done_evt_s && !bus_we_r) begin
                case (bus_id_r)
                    ID_IC:   ic_rdata_r <= bus_rdata;
                    ID_DC:   dc_rdata_r <= bus_rdata;
                    ID_UC:   uc_rdata_r <= bus_rdata[31:0];
                    default: uc_rdata_r <= uc_rdata_r;
                endcase
            end
        end
    end

    assign bus_valid = bus_valid_r;
    assign bus_id    = bus_id_r;
    assign bus_we    = bus_we_r;
    assign bus_line  = bus_line_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wstrb = bus_wstrb_r;
    assign bus_wdata = bus_wdata_r;
    assign busy      = busy_r;
    assign ic_done   = ic_done_r;
    assign dc_done   = dc_done_r;
    assign uc_done   = uc_done_r;
    assign ic_rdata  = ic_rdata_r;
    assign dc_rdata  = dc_rdata_r;
    assign uc_rdata  = uc_rdata_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed, table-driven bench for mem_req_arbiter plus hand-written
// sequences for priority ordering, stalls, reset abort and aging/starvation.
module tb_mem_req_arbiter;

    localparam int CLW = 512;
    typedef logic [CLW-1:0] line_t;

`ifdef ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, uc_req = 1'b0;
    logic [31:0] ic_addr = 32'd0, dc_addr = 32'd0, uc_addr = 32'd0, uc_wdata = 32'd0;
    logic [3:0]  uc_wstrb = 4'd0;
    line_t       dc_wdata = '0;
    logic        ic_done, dc_done, uc_done;
    line_t       ic_rdata, dc_rdata;
    logic [31:0] uc_rdata;
    logic        bus_valid, bus_we, bus_line, busy;
    logic        bus_ready = 1'b0, bus_done = 1'b0;
    logic [1:0]  bus_id;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    line_t       bus_wdata;
    line_t       bus_rdata = '0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.CL_WIDTH(CLW), .AGE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .dc_rdata(dc_rdata),
        .uc_req(uc_req), .uc_wstrb(uc_wstrb), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
        .uc_done(uc_done), .uc_rdata(uc_rdata),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_id(bus_id), .bus_we(bus_we),
        .bus_line(bus_line), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_done(bus_done), .bus_rdata(bus_rdata), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected read-data registers (scoreboard).
    line_t       sb_ic = '0;
    line_t       sb_dc = '0;
    logic [31:0] sb_uc = 32'd0;

    task automatic chk(input string name, input line_t act, input line_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " bus_valid"}, line_t'(bus_valid), '0);
        chk({tag, " bus_id"},    line_t'(bus_id), '0);
        chk({tag, " bus_we"},    line_t'(bus_we), '0);
        chk({tag, " bus_line"},  line_t'(bus_line), '0);
        chk({tag, " bus_addr"},  line_t'(bus_addr), '0);
        chk({tag, " bus_wstrb"}, line_t'(bus_wstrb), '0);
        chk({tag, " bus_wdata"}, bus_wdata, '0);
        chk({tag, " busy"},      line_t'(busy), '0);
        chk({tag, " dones"},     line_t'({uc_done, dc_done, ic_done}), '0);
        chk({tag, " ic_rdata"},  ic_rdata, '0);
        chk({tag, " dc_rdata"},  dc_rdata, '0);
        chk({tag, " uc_rdata"},  line_t'(uc_rdata), '0);
    endtask

    // One full transaction, entered at a negedge with requests already driven.
    // drop = {uc,dc,ic}: requests released during the RESP cycle.
    task automatic do_txn(input string tag, input logic [1:0] eid, input logic ewe,
                          input logic eline, input logic [3:0] ews, input logic [31:0] eaddr,
                          input line_t ewd, input int rdly, input int ddly,
                          input line_t rd, input logic [2:0] drop);
        int k;
        logic [31:0] sa_ic, sa_dc, sa_uc;
        logic [2:0] onehot;
        k = 0;
        while (!bus_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus_valid) begin
            fail_now({tag, " valid"});
            return;
        end
        chk({tag, " latency"}, line_t'(k), line_t'(1));
        chk({tag, " id"},    line_t'(bus_id), line_t'(eid));
        chk({tag, " we"},    line_t'(bus_we), line_t'(ewe));
        chk({tag, " line"},  line_t'(bus_line), line_t'(eline));
        chk({tag, " wstrb"}, line_t'(bus_wstrb), line_t'(ews));
        chk({tag, " addr"},  line_t'(bus_addr), line_t'(eaddr));
        chk({tag, " wdata"}, bus_wdata, ewd);
        chk({tag, " busy"},  line_t'(busy), line_t'(1));
        // Stall in ISSUE while wiggling request inputs and a stray bus_done.
        sa_ic = ic_addr; sa_dc = dc_addr; sa_uc = uc_addr;
        for (int i = 0; i < rdly; i++) begin
            ic_addr = ~ic_addr; dc_addr = ~dc_addr; uc_addr = ~uc_addr;
            bus_done = 1'b1;
            @(negedge clk);
            bus_done = 1'b0;
            chk({tag, " stall valid"}, line_t'(bus_valid), line_t'(1));
            chk({tag, " stall addr"},  line_t'(bus_addr), line_t'(eaddr));
            chk({tag, " stall id"},    line_t'(bus_id), line_t'(eid));
            chk({tag, " stall wdata"}, bus_wdata, ewd);
        end
        ic_addr = sa_ic; dc_addr = sa_dc; uc_addr = sa_uc;
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        chk({tag, " valid drop"}, line_t'(bus_valid), '0);
        for (int i = 0; i < ddly; i++) begin
            bus_ready = 1'b1;
            @(negedge clk);
            bus_ready = 1'b0;
            chk({tag, " wait dones"}, line_t'({uc_done, dc_done, ic_done}), '0);
        end
        bus_done  = 1'b1;
        bus_rdata = rd;
        @(negedge clk);
        bus_done  = 1'b0;
        bus_rdata = ~rd;
        if (!ewe) begin
            case (eid)
                2'd0:    sb_ic = rd;
                2'd1:    sb_dc = rd;
                default: sb_uc = rd[31:0];
            endcase
        end
        onehot = 3'b001 << eid;
        chk({tag, " done"},     line_t'({uc_done, dc_done, ic_done}), line_t'(onehot));
        chk({tag, " ic_rdata"}, ic_rdata, sb_ic);
        chk({tag, " dc_rdata"}, dc_rdata, sb_dc);
        chk({tag, " uc_rdata"}, line_t'(uc_rdata), line_t'(sb_uc));
        if (drop[0]) ic_req = 1'b0;
        if (drop[1]) dc_req = 1'b0;
        if (drop[2]) uc_req = 1'b0;
        @(negedge clk);
        chk({tag, " post dones"}, line_t'({uc_done, dc_done, ic_done}), '0);
        chk({tag, " post busy"},  line_t'(busy), '0);
        chk({tag, " post valid"}, line_t'(bus_valid), '0);
        chk({tag, " held rdata"}, dc_rdata ^ ic_rdata, sb_dc ^ sb_ic);
    endtask

    typedef struct {
        logic        ic;
        logic        dc;
        logic        dc_we;
        logic        uc;
        logic [3:0]  uc_wstrb;
        logic [31:0] addr;
        logic [31:0] wd;
        int          rdly;
        int          ddly;
        logic [1:0]  eid;
        logic        ewe;
        logic        eline;
        logic [3:0]  ews;
    } vec_t;

    vec_t vecs[9];

    initial begin
        line_t ewd;
        line_t rd;
        int    k;
        logic [1:0] eid;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h1FC0_0000, 32'h0000_0000, 0, 3, 2'd0, 1'b0, 1'b1, 4'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h8000_1000, 32'h1111_2222, 0, 0, 2'd1, 1'b0, 1'b1, 4'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h8000_2040, 32'hCAFE_F00D, 2, 1, 2'd1, 1'b1, 1'b1, 4'hF};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 32'hBFD0_F000, 32'h0000_1234, 1, 2, 2'd2, 1'b1, 1'b0, 4'h3};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'hBFD0_F004, 32'hDEAD_0004, 0, 1, 2'd2, 1'b0, 1'b0, 4'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'hBFD0_F010, 32'h5555_AAAA, 0, 0, 2'd2, 1'b1, 1'b0, 4'hF};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 32'h8000_3000, 32'h0BAD_BEEF, 1, 0, 2'd1, 1'b0, 1'b1, 4'h0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'h8000_3040, 32'h7777_8888, 0, 2, 2'd1, 1'b1, 1'b1, 4'hF};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h1FC0_0040, 32'h0000_0000, 1, 5, 2'd0, 1'b0, 1'b1, 4'h0};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", line_t'(busy), '0);

        // Table-driven single transactions.
        for (int i = 0; i < 9; i++) begin
            ic_req   = vecs[i].ic;
            dc_req   = vecs[i].dc;
            dc_we    = vecs[i].dc_we;
            uc_req   = vecs[i].uc;
            uc_wstrb = vecs[i].uc_wstrb;
            ic_addr  = vecs[i].addr;
            dc_addr  = vecs[i].addr;
            uc_addr  = vecs[i].addr;
            dc_wdata = {16{vecs[i].wd}};
            uc_wdata = vecs[i].wd;
            if (vecs[i].eid == 2'd1 && vecs[i].ewe) ewd = {16{vecs[i].wd}};
            else if (vecs[i].eid == 2'd2)           ewd = line_t'(vecs[i].wd);
            else                                     ewd = '0;
            rd = {{15{vecs[i].wd ^ 32'hA5A5_5A5A}}, 32'h0000_0100 + 32'(i)};
            do_txn($sformatf("vec%0d", i), vecs[i].eid, vecs[i].ewe, vecs[i].eline,
                   vecs[i].ews, vecs[i].addr, ewd, vecs[i].rdly, vecs[i].ddly, rd, 3'b111);
        end

        // dc and ic together: dc first, ic after exactly one IDLE cycle.
        ic_req = 1'b1; ic_addr = 32'h1FC0_0080;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h8000_4000;
        do_txn("pair dc", 2'd1, 1'b0, 1'b1, 4'h0, 32'h8000_4000, '0, 0, 1, {16{32'h0D0D_0001}}, 3'b010);
        do_txn("pair ic", 2'd0, 1'b0, 1'b1, 4'h0, 32'h1FC0_0080, '0, 0, 0, {16{32'h1C1C_0002}}, 3'b001);

        // Ten-cycle bus_ready stall on a line write-back.
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h8000_5000; dc_wdata = {16{32'h3C3C_C3C3}};
        do_txn("stall", 2'd1, 1'b1, 1'b1, 4'hF, 32'h8000_5000, {16{32'h3C3C_C3C3}}, 10, 0, '1, 3'b111);

        // Reset while in WAIT: immediate reset values, no done pulse afterwards.
        uc_req = 1'b1; uc_wstrb = 4'h0; uc_addr = 32'hBFD0_F008; uc_wdata = 32'h0;
        k = 0;
        while (!bus_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus_valid) fail_now("rstwait valid");
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        chk("rstwait busy", line_t'(busy), line_t'(1));
        rst = 1'b1;
        #1;
        sb_ic = '0; sb_dc = '0; sb_uc = 32'd0;
        chk_reset_outputs("rst in wait");
        uc_req   = 1'b0;
        bus_done = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        bus_done = 1'b0;
        @(negedge clk);
        chk("after rst dones", line_t'({uc_done, dc_done, ic_done}), '0);
        chk("after rst busy",  line_t'(busy), '0);
        ic_req = 1'b1; ic_addr = 32'h0000_1000;
        do_txn("after rst", 2'd0, 1'b0, 1'b1, 4'h0, 32'h0000_1000, '0, 0, 0, {16{32'h600D_0003}}, 3'b001);

        // Continuous dc traffic with a pending icache request.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_ic = '0; sb_dc = '0; sb_uc = 32'd0;
        @(negedge clk);
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h8000_8000;
        ic_req = 1'b1; ic_addr = 32'h1FC0_0100;
        for (int s = 1; s <= 10; s++) begin
            eid = (AGING && s == 9) ? 2'd0 : 2'd1;
            do_txn($sformatf("age sel%0d", s), eid, 1'b0, 1'b1, 4'h0,
                   (eid == 2'd0) ? 32'h1FC0_0100 : 32'h8000_8000, '0, 0, 0,
                   {16{32'hA9E0_0000 + 32'(s)}}, 3'b000);
        end
        dc_req = 1'b0;
        ic_req = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares the single AXI bridge transaction port between three memory requesters: instruction-cache line refill, data-cache line refill/write-back, and uncached single-word access. Each cycle it is idle, it picks one pending request by priority (with optional aging), latches it, and issues it downstream. It waits for completion, then returns read data and a one-cycle done pulse to the winner. It sits between the cache/uncache units and the AXI bridge and replaces ad-hoc request ORing with one-transaction-at-a-time sequencing.

## Interface
- CL_WIDTH, 512, cache line width in bits (16 x 32-bit words)
- AGE_LIMIT, 8, arbitration losses before a pending requester is promoted (range 1..15)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ic_req  in  1  icache refill request, held until ic_done
- ic_addr  in  32  line address
- ic_done  out  1  one-cycle completion pulse
- ic_rdata  out  CL_WIDTH  refilled line, valid with ic_done, held after
- dc_req  in  1  dcache request, held until dc_done
- dc_we  in  1  1 = line write-back, 0 = line refill
- dc_addr  in  32  line address
- dc_wdata  in  CL_WIDTH  write-back line
- dc_done  out  1  completion pulse
- dc_rdata  out  CL_WIDTH  refilled line (unchanged on write-back)
- uc_req  in  1  uncached request, held until uc_done
- uc_wstrb  in  4  byte strobes; 0 = read
- uc_addr  in  32  word address
- uc_wdata  in  32  write data
- uc_done  out  1  completion pulse
- uc_rdata  out  32  read data (unchanged on write)
- bus_valid  out  1  transaction valid to bridge
- bus_ready  in  1  bridge accepted transaction
- bus_id  out  2  source: 0 icache, 1 dcache, 2 uncache
- bus_we  out  1  write transaction
- bus_line  out  1  1 = 16-beat line burst, 0 = single beat
- bus_addr  out  32
- bus_wstrb  out  4  4'b1111 for line writes, uc_wstrb for uncached
- bus_wdata  out  CL_WIDTH  uncached data in bits [31:0], upper bits zero
- bus_done  in  1  bridge completion pulse (after B response or last R beat)
- bus_rdata  in  CL_WIDTH  read data, valid with bus_done; uncached in [31:0]
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, select the winner, latch its id/addr/we/wstrb/wdata into bus_* registers, set bus_valid=1, and go to ISSUE. If no req is high, stay in IDLE.
- ISSUE: hold all bus_* stable. When bus_ready=1, clear bus_valid and go to WAIT.
- WAIT: when bus_done=1, capture bus_rdata into the winner's rdata register (reads only) and go to RESP.
- RESP: assert the winner's done for exactly this cycle, then go to IDLE.
- Base priority: dc > uc > ic.
- The latched request is immune to input changes. A req dropped before selection is never issued.
- One outstanding transaction only. A requester re-raising req in its RESP cycle is eligible in the next IDLE.
- Reset values: all done=0, all rdata=0, bus_valid=0, bus_id=0, bus_we=0, bus_line=0, bus_addr=0, bus_wstrb=0, bus_wdata=0, busy=0, state=IDLE, age counters=0.
- Reset mid-transaction aborts to IDLE with no done pulse. Requesters re-request after reset.

## Timing
- Request latency: req high at edge N while IDLE gives bus_valid=1 after edge N.
- bus_valid and payload change only on entering ISSUE. Payload is stable until the bus_ready handshake.
- Done fires 1 cycle after the bus_done edge. Minimum total occupancy is 4 cycles (IDLE, ISSUE, WAIT, RESP) with bus_ready and bus_done both in their first eligible cycle.
- Back-to-back: at least one IDLE cycle between consecutive transactions.
- bus_done while not in WAIT is ignored.
- bus_ready while not in ISSUE is ignored.

## Configuration
- ARB_AGING_EN defined:
  - Each requester has a 4-bit age counter. It increments (saturating at AGE_LIMIT) when that requester's req is high during an IDLE selection it loses.
  - It clears when that requester wins.
  - A requester with age == AGE_LIMIT beats base priority. Ties among aged requesters use base priority.
- ARB_AGING_EN undefined: strict base priority, no counters. icache may starve under continuous dcache traffic.

## Test plan
- ic_req only, addr 0x1FC0_0000, bus_ready and bus_done after 3 cycles in WAIT -> bus_id=0, bus_line=1, bus_we=0, ic_done one-cycle pulse, ic_rdata equals bus_rdata.
- dc_req (we=0) and ic_req raised together -> dcache issued first, icache issued after dc_done plus one IDLE cycle.
- uc write, wstrb=4'b0011, addr 0xBFD0_F000, wdata 0x1234 -> bus_we=1, bus_line=0, bus_wstrb=0011, bus_wdata[31:0]=0x1234, uc_rdata unchanged.
- ARB_AGING_EN with AGE_LIMIT=8: dc_req held high continuously plus ic_req -> ic issued on the 9th selection. Without the macro, ic never issued while dc_req remains high.
- rst asserted while in WAIT -> all outputs reset values immediately, no done pulse, next req handled normally.
- bus_ready held low 10 cycles in ISSUE -> bus_addr/bus_id/bus_wdata stable throughout, bus_valid stays 1.
